// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the sync_fifo_param family.
// Optional feature macro: SYNC_FIFO_FWFT_EN (first-word-fall-through read port).
package sync_fifo_pkg;

  localparam int unsigned DEF_DWIDTH = 8;
  localparam int unsigned DEF_DEPTH  = 8;

  // Ceiling log2, used to size pointers (AW) and the fill counter (AW+1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of sync_fifo_param; the FIFO takes the slave side.
interface sync_fifo_param_if #(
  parameter int unsigned DWIDTH = sync_fifo_pkg::DEF_DWIDTH,
  parameter int unsigned DEPTH  = sync_fifo_pkg::DEF_DEPTH
);
  import sync_fifo_pkg::*;

  localparam int unsigned AW = clog2(DEPTH);

  logic              clr_i;
  logic              wr_en_i;
  logic [DWIDTH-1:0] data_i;
  logic              full_o;
  logic              almost_full_o;
  logic              rd_en_i;
  logic [DWIDTH-1:0] data_o;
  logic              valid_o;
  logic              empty_o;
  logic              almost_empty_o;
  logic [AW:0]       count_o;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
    output clr_i, wr_en_i, data_i, rd_en_i,
    input  full_o, almost_full_o, data_o, valid_o, empty_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

  modport slave (
    input  clr_i, wr_en_i, data_i, rd_en_i,
    output full_o, almost_full_o, data_o, valid_o, empty_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/sync_fifo_ptr.sv
// Wrapping AW-bit FIFO pointer; flush has priority over increment.
module sync_fifo_ptr #(
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] r_ptr;

  // Pointer register: wraps DEPTH-1 -> 0 through natural overflow.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_ptr <= '0;
    end else if (clr_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill level, thresholds, error pulses
// and synchronous flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is a
// registered read port with one cycle of read latency.
module sync_fifo_param import sync_fifo_pkg::*; #(
  parameter int unsigned DWIDTH    = DEF_DWIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_MARGIN = 1,
  parameter int unsigned AE_MARGIN = 1
) (
  input  logic             clk,
  input  logic             reset_i,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned AW   = clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AF   = (AW+1)'(DEPTH - AF_MARGIN);
  localparam logic [AW:0] C_AE   = (AW+1)'(AE_MARGIN);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_MARGIN >= DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_MARGIN must be below DEPTH");
  end
  if (AE_MARGIN >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_param: AE_MARGIN must be below DEPTH");
  end

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]     w_wr_ptr;
  logic [AW-1:0]     w_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_full;
  logic              w_empty;
  logic              w_rd_acc;
  logic              w_wr_acc;

  assign w_full   = (r_count == C_FULL);
  assign w_empty  = (r_count == '0);
  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // that arrives together with a read.
  assign w_rd_acc = bus.rd_en_i & ~w_empty;
  assign w_wr_acc = bus.wr_en_i & (~w_full | w_rd_acc);

  sync_fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk     (clk),
    .reset_i (reset_i),
    .clr_i   (bus.clr_i),
    .inc_i   (w_wr_acc),
    .ptr_o   (w_wr_ptr)
  );

  sync_fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk     (clk),
    .reset_i (reset_i),
    .clr_i   (bus.clr_i),
    .inc_i   (w_rd_acc),
    .ptr_o   (w_rd_ptr)
  );

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !bus.clr_i) begin
      r_mem[w_wr_ptr] <= bus.data_i;
    end
  end

  // Fill level: flush first, then net change of the accepted requests.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_count <= '0;
    end else if (bus.clr_i) begin
      r_count <= '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      r_count <= r_count + 1'b1;
    end else if (!w_wr_acc && w_rd_acc) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Registered one-cycle error pulses for rejected requests.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clr_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= bus.wr_en_i & ~w_wr_acc;
      r_underflow <= bus.rd_en_i & ~w_rd_acc;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word shown combinationally; forced to zero while empty so the port
  // never exposes stale, unreset memory.
  assign bus.data_o  = w_empty ? '0 : r_mem[w_rd_ptr];
  assign bus.valid_o = ~w_empty;
`else
  logic [DWIDTH-1:0] r_data;
  logic              r_valid;

  // Registered read port: word captured on an accepted read, held otherwise.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (bus.clr_i) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_data <= r_mem[w_rd_ptr];
      end
    end
  end

  assign bus.data_o  = r_data;
  assign bus.valid_o = r_valid;
`endif

  assign bus.full_o         = w_full;
  assign bus.empty_o        = w_empty;
  assign bus.almost_full_o  = (r_count >= C_AF);
  assign bus.almost_empty_o = (r_count <= C_AE);
  assign bus.count_o        = r_count;
  assign bus.overflow_o     = r_overflow;
  assign bus.underflow_o    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DWIDTH=8, DEPTH=8).
// Expectations follow SYNC_FIFO_FWFT_EN when it is defined.
module tb_sync_fifo_param;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 8;

  logic clk;
  logic reset_i;
  int   n_cmp = 0;
  int   n_bad = 0;

  sync_fifo_param_if #(.DWIDTH(DW), .DEPTH(DP)) bus ();

  sync_fifo_param #(
    .DWIDTH    (DW),
    .DEPTH     (DP),
    .AF_MARGIN (1),
    .AE_MARGIN (1)
  ) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.clr_i   = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.data_i = '0;
    reset_i = 1'b0;
    repeat (2) cyc();
    reset_i = 1'b1;
    cyc();
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", bus.empty_o); end
    n_cmp++; if (bus.count_o !== 4'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", bus.count_o); end
    // traffic, then async reset between edges
    bus.wr_en_i = 1'b1; bus.data_i = 8'hA5; cyc();
    bus.data_i = 8'h5A; cyc();
    bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b1; cyc();
    bus.rd_en_i = 1'b0;
    n_cmp++; if (bus.valid_o !== 1'b1) begin n_bad++; $display("FAIL pre_rst_valid: got %b want 1", bus.valid_o); end
    n_cmp++; if (bus.count_o !== 4'd1) begin n_bad++; $display("FAIL pre_rst_count: got %0d want 1", bus.count_o); end
    #3;
    reset_i = 1'b0;
    #1;
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_bad++; $display("FAIL arst_empty: got %b want 1", bus.empty_o); end
    n_cmp++; if (bus.count_o !== 4'd0) begin n_bad++; $display("FAIL arst_count: got %0d want 0", bus.count_o); end
    n_cmp++; if (bus.data_o !== 8'h00) begin n_bad++; $display("FAIL arst_data: got %h want 00", bus.data_o); end
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b want 0", bus.valid_o); end
    #1;
    reset_i = 1'b1;
    cyc();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      bus.wr_en_i = 1'b1; bus.data_i = 8'(i);
      cyc();
      n_cmp++; if (bus.count_o !== 4'(i)) begin n_bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count_o, i); end
      n_cmp++; if (bus.full_o !== (i == 8)) begin n_bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full_o, (i == 8)); end
      n_cmp++; if (bus.almost_full_o !== (i >= 7)) begin n_bad++; $display("FAIL fill_afull[%0d]: got %b want %b", i, bus.almost_full_o, (i >= 7)); end
    end
    bus.data_i = 8'h99;
    cyc();
    bus.wr_en_i = 1'b0;
    n_cmp++; if (bus.overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b want 1", bus.overflow_o); end
    n_cmp++; if (bus.count_o !== 4'd8) begin n_bad++; $display("FAIL ovf_count: got %0d want 8", bus.count_o); end
    cyc();
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", bus.overflow_o); end
    for (int i = 1; i <= 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      n_cmp++; if (bus.data_o !== 8'(i)) begin n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.data_o, 8'(i)); end
      n_cmp++; if (bus.valid_o !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d]: got %b want 1", i, bus.valid_o); end
`endif
      bus.rd_en_i = 1'b1;
      cyc();
`ifndef SYNC_FIFO_FWFT_EN
      n_cmp++; if (bus.data_o !== 8'(i)) begin n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.data_o, 8'(i)); end
      n_cmp++; if (bus.valid_o !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d]: got %b want 1", i, bus.valid_o); end
`endif
      n_cmp++; if (bus.count_o !== 4'(8 - i)) begin n_bad++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus.count_o, 8 - i); end
      n_cmp++; if (bus.almost_empty_o !== ((8 - i) <= 1)) begin n_bad++; $display("FAIL drain_aempty[%0d]: got %b want %b", i, bus.almost_empty_o, ((8 - i) <= 1)); end
    end
    bus.rd_en_i = 1'b0;
    cyc();
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_bad++; $display("FAIL drained_empty: got %b want 1", bus.empty_o); end
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL drained_valid: got %b want 0", bus.valid_o); end
  endtask

  task automatic test_wrap();
    int n;
    logic [7:0] base;
    for (int p = 0; p < 2; p++) begin
      n    = (p == 0) ? 5 : 8;
      base = (p == 0) ? 8'h10 : 8'h20;
      for (int i = 0; i < n; i++) begin
        bus.wr_en_i = 1'b1; bus.data_i = base + 8'(i);
        cyc();
        n_cmp++; if (bus.count_o !== 4'(i + 1)) begin n_bad++; $display("FAIL wrap_wcount[%0d.%0d]: got %0d want %0d", p, i, bus.count_o, i + 1); end
      end
      bus.wr_en_i = 1'b0;
      for (int i = 0; i < n; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
        n_cmp++; if (bus.data_o !== base + 8'(i)) begin n_bad++; $display("FAIL wrap_data[%0d.%0d]: got %h want %h", p, i, bus.data_o, base + 8'(i)); end
`endif
        bus.rd_en_i = 1'b1;
        cyc();
`ifndef SYNC_FIFO_FWFT_EN
        n_cmp++; if (bus.data_o !== base + 8'(i)) begin n_bad++; $display("FAIL wrap_data[%0d.%0d]: got %h want %h", p, i, bus.data_o, base + 8'(i)); end
`endif
        n_cmp++; if (bus.count_o !== 4'(n - 1 - i)) begin n_bad++; $display("FAIL wrap_rcount[%0d.%0d]: got %0d want %0d", p, i, bus.count_o, n - 1 - i); end
      end
      bus.rd_en_i = 1'b0;
      cyc();
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      bus.wr_en_i = 1'b1; bus.data_i = 8'h30 + 8'(i);
      cyc();
    end
    n_cmp++; if (bus.full_o !== 1'b1) begin n_bad++; $display("FAIL sim_full: got %b want 1", bus.full_o); end
`ifdef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.data_o !== 8'h30) begin n_bad++; $display("FAIL sim_head: got %h want 30", bus.data_o); end
`endif
    // full + write + read
    bus.data_i = 8'h3F; bus.rd_en_i = 1'b1;
    cyc();
    bus.wr_en_i = 1'b0;
    n_cmp++; if (bus.count_o !== 4'd8) begin n_bad++; $display("FAIL simfull_count: got %0d want 8", bus.count_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_bad++; $display("FAIL simfull_ovf: got %b want 0", bus.overflow_o); end
`ifndef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.data_o !== 8'h30) begin n_bad++; $display("FAIL simfull_data: got %h want 30", bus.data_o); end
`endif
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? (8'h31 + 8'(i)) : 8'h3F;
`ifdef SYNC_FIFO_FWFT_EN
      n_cmp++; if (bus.data_o !== exp) begin n_bad++; $display("FAIL simfull_order[%0d]: got %h want %h", i, bus.data_o, exp); end
`endif
      bus.rd_en_i = 1'b1;
      cyc();
`ifndef SYNC_FIFO_FWFT_EN
      n_cmp++; if (bus.data_o !== exp) begin n_bad++; $display("FAIL simfull_order[%0d]: got %h want %h", i, bus.data_o, exp); end
`endif
    end
    bus.rd_en_i = 1'b0;
    cyc();
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_bad++; $display("FAIL simfull_empty: got %b want 1", bus.empty_o); end
    // empty + write + read
    bus.wr_en_i = 1'b1; bus.data_i = 8'h44; bus.rd_en_i = 1'b1;
    cyc();
    bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0;
    n_cmp++; if (bus.underflow_o !== 1'b1) begin n_bad++; $display("FAIL simempty_udf: got %b want 1", bus.underflow_o); end
    n_cmp++; if (bus.count_o !== 4'd1) begin n_bad++; $display("FAIL simempty_count: got %0d want 1", bus.count_o); end
`ifdef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.data_o !== 8'h44) begin n_bad++; $display("FAIL simempty_data: got %h want 44", bus.data_o); end
    n_cmp++; if (bus.valid_o !== 1'b1) begin n_bad++; $display("FAIL simempty_valid: got %b want 1", bus.valid_o); end
`else
    n_cmp++; if (bus.data_o !== 8'h3F) begin n_bad++; $display("FAIL simempty_data: got %h want 3f", bus.data_o); end
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL simempty_valid: got %b want 0", bus.valid_o); end
`endif
    cyc();
    n_cmp++; if (bus.underflow_o !== 1'b0) begin n_bad++; $display("FAIL simempty_udf_clr: got %b want 0", bus.underflow_o); end
    bus.rd_en_i = 1'b1;
    cyc();
    bus.rd_en_i = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.data_o !== 8'h44) begin n_bad++; $display("FAIL simempty_read: got %h want 44", bus.data_o); end
`endif
    n_cmp++; if (bus.count_o !== 4'd0) begin n_bad++; $display("FAIL simempty_final: got %0d want 0", bus.count_o); end
    cyc();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      bus.wr_en_i = 1'b1; bus.data_i = 8'h50 + 8'(i);
      cyc();
    end
    n_cmp++; if (bus.count_o !== 4'd4) begin n_bad++; $display("FAIL flush_pre: got %0d want 4", bus.count_o); end
    bus.clr_i = 1'b1; bus.data_i = 8'h77;
    cyc();
    idle();
    n_cmp++; if (bus.count_o !== 4'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", bus.count_o); end
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_bad++; $display("FAIL flush_empty: got %b want 1", bus.empty_o); end
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", bus.valid_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin n_bad++; $display("FAIL flush_err: got %b%b want 00", bus.overflow_o, bus.underflow_o); end
`ifndef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.data_o !== 8'h44) begin n_bad++; $display("FAIL flush_hold: got %h want 44", bus.data_o); end
`endif
    cyc();
    n_cmp++; if (bus.count_o !== 4'd0) begin n_bad++; $display("FAIL flush_nowrite: got %0d want 0", bus.count_o); end
    bus.wr_en_i = 1'b1; bus.data_i = 8'h60;
    cyc();
    bus.wr_en_i = 1'b0;
    n_cmp++; if (bus.count_o !== 4'd1) begin n_bad++; $display("FAIL flush_after_wr: got %0d want 1", bus.count_o); end
`ifdef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.data_o !== 8'h60) begin n_bad++; $display("FAIL flush_after_data: got %h want 60", bus.data_o); end
`endif
    bus.rd_en_i = 1'b1;
    cyc();
    bus.rd_en_i = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.data_o !== 8'h60) begin n_bad++; $display("FAIL flush_after_data: got %h want 60", bus.data_o); end
`endif
    cyc();
  endtask

  task automatic test_underflow();
    logic [7:0] hold;
`ifdef SYNC_FIFO_FWFT_EN
    hold = 8'h00;
`else
    hold = 8'h60;
`endif
    bus.rd_en_i = 1'b1;
    cyc();
    bus.rd_en_i = 1'b0;
    n_cmp++; if (bus.underflow_o !== 1'b1) begin n_bad++; $display("FAIL udf_pulse: got %b want 1", bus.underflow_o); end
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL udf_valid: got %b want 0", bus.valid_o); end
    n_cmp++; if (bus.data_o !== hold) begin n_bad++; $display("FAIL udf_data: got %h want %h", bus.data_o, hold); end
    n_cmp++; if (bus.count_o !== 4'd0) begin n_bad++; $display("FAIL udf_count: got %0d want 0", bus.count_o); end
    cyc();
    n_cmp++; if (bus.underflow_o !== 1'b0) begin n_bad++; $display("FAIL udf_one_cycle: got %b want 0", bus.underflow_o); end
    n_cmp++; if (bus.data_o !== hold) begin n_bad++; $display("FAIL udf_data_hold: got %h want %h", bus.data_o, hold); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_underflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
